// File: rtl/cdp1802_cycle_sequencer.sv
// cdp1802_cycle_sequencer: machine-cycle sequencer with S2 DMA / S3 interrupt insertion,
// R0 DMA pointer and TPA/TPB timing pulses.
module cdp1802_cycle_sequencer #(
   parameter int TICKS  = 8,
   parameter int ADDR_W = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clk_enable,
   input  logic              dma_in_req,
   input  logic              dma_out_req,
   input  logic              int_req,
   input  logic              ie,
   input  logic [1:0]        core_next,
   input  logic              r0_load,
   input  logic [ADDR_W-1:0] r0_load_val,
   output logic [1:0]        sc,
   output logic              tpa,
   output logic              tpb,
   output logic              cycle_start,
   output logic [ADDR_W-1:0] dma_addr,
   output logic              dma_rd,
   output logic              dma_wr,
   output logic              int_ack,
   output logic              core_stall
);
   localparam int TW = $clog2(TICKS);
   localparam logic [1:0] S0 = 2'b00, S1 = 2'b01, S2 = 2'b10, S3 = 2'b11;
   logic [TW-1:0] tick;
   logic [1:0] sc_next;
   logic dir_in, last, en;
   assign last = tick == TW'(TICKS - 1);
   assign en = clk_enable & ~reset;
   // DMA beats interrupts; S0 always runs straight into S1; S3 never repeats
   always_comb
      sc_next = sc == S0                 ? S1 :
                dma_in_req | dma_out_req ? S2 :
                sc == S3                 ? S0 :
                int_req & ie             ? S3 : {1'b0, core_next[0]};
   assign cycle_start = en & tick == '0;
   assign tpa = en & tick == TW'(1);
   assign tpb = en & tick == TW'(TICKS - 2);
   assign dma_rd = tpb & sc == S2 & ~dir_in;
   assign dma_wr = tpb & sc == S2 & dir_in;
   assign int_ack = cycle_start & sc == S3;
   assign core_stall = sc[1];
   always_ff @(posedge clk)
      if (reset) begin
         tick <= '0;
         sc <= S1;
         dma_addr <= '0;
         dir_in <= 1'b0;
      end else if (clk_enable) begin
         tick <= last ? '0 : tick + TW'(1);
         if (last) begin
            sc <= sc_next;
            dir_in <= dma_in_req;
         end
         if (r0_load) dma_addr <= r0_load_val;
         else if (last && sc == S2) dma_addr <= dma_addr + ADDR_W'(1);
      end
endmodule
